// File: rtl/store_buffer_ctrl_pkg.sv
// Shared types for the store buffer: entry layout, arbiter states and address helpers.
package ls_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_WAIT = 2'd1,
    LD_WAIT = 2'd2
  } arb_state_e;

  // Stores and loads match on the 32-bit word, byte lanes are resolved by byte enables.
  function automatic logic [29:0] word_addr(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/store_buffer_ctrl_if.sv
// MEM-stage store/load handshakes plus the single data-memory port.
interface store_buffer_ctrl_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_be;
  logic        ld_ready;
  logic        ld_sel_fwd;
  logic [31:0] ld_fwd_data;
  logic        fence;
  logic        fence_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;

  modport master (
    output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, ld_be, fence, mem_gnt,
    input  st_ready, ld_ready, ld_sel_fwd, ld_fwd_data, fence_done,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, ld_be, fence, mem_gnt,
    output st_ready, ld_ready, ld_sel_fwd, ld_fwd_data, fence_done,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_buffer_ctrl_match.sv
// Combinational youngest-hit finder: scans backward from tail-1 so the newest matching store wins.
module sb_match
  import ls_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]      tail,
  input  logic [31:0]           ld_addr,
  input  logic [3:0]            ld_be,
  output logic                  any_hit,
  output logic                  fwd_ok,
  output logic [31:0]           fwd_data
);

  logic [PTR_W-1:0] idx_s;
  logic             hit_s;
  logic             take_s;
  logic [3:0]       hit_be_s;

  // Youngest-first search; the first hit latches and later (older) hits are ignored
  always_comb begin
    any_hit  = 1'b0;
    hit_be_s = 4'h0;
    fwd_data = 32'h0;
    idx_s    = '0;
    hit_s    = 1'b0;
    take_s   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s    = tail - PTR_W'(k + 1);
      hit_s    = entries[idx_s].valid && (word_addr(entries[idx_s].addr) == word_addr(ld_addr));
      take_s   = hit_s && !any_hit;
      hit_be_s = take_s ? entries[idx_s].be   : hit_be_s;
      fwd_data = take_s ? entries[idx_s].data : fwd_data;
      any_hit  = any_hit || hit_s;
    end
    fwd_ok = any_hit && ((ld_be & ~hit_be_s) == 4'h0);
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Store buffer FIFO with load forwarding and a drain/load arbiter for the single data-memory port.
module store_buffer_ctrl
  import ls_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst_n,
  store_buffer_ctrl_if.slave bus
);

  sb_entry_t [DEPTH-1:0] entries_r;
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [PTR_W:0]        count_r;
  arb_state_e            state_r;
  arb_state_e            state_s;

  logic        any_hit_s;
  logic        fwd_ok_s;
  logic [31:0] fwd_data_s;
  logic        full_s;
  logic        enq_s;
  logic        deq_s;
  logic        stall_s;
  logic        drain_cond_s;
  logic        ld_miss_s;
  logic        drive_st_s;
  logic        drive_ld_s;
  sb_entry_t   head_s;

  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries  (entries_r),
    .tail     (tail_r),
    .ld_addr  (bus.ld_addr),
    .ld_be    (bus.ld_be),
    .any_hit  (any_hit_s),
    .fwd_ok   (fwd_ok_s),
    .fwd_data (fwd_data_s)
  );

  assign full_s       = (count_r == (PTR_W + 1)'(DEPTH));
  assign enq_s        = bus.st_valid && !full_s;
  assign stall_s      = bus.ld_valid && any_hit_s && !fwd_ok_s;
  assign ld_miss_s    = bus.ld_valid && !any_hit_s;
  // Loads get the port first unless the buffer is full, fenced, or blocking that very load.
  assign drain_cond_s = (count_r != '0) && (!bus.ld_valid || full_s || bus.fence || stall_s);
  assign head_s       = entries_r[head_r];
  assign deq_s        = drive_st_s && bus.mem_gnt;

  assign bus.st_ready    = !full_s;
  assign bus.ld_sel_fwd  = bus.ld_valid && fwd_ok_s;
  assign bus.ld_fwd_data = (bus.ld_valid && fwd_ok_s) ? fwd_data_s : 32'h0;
  assign bus.ld_ready    = (bus.ld_valid && fwd_ok_s) || (drive_ld_s && bus.mem_gnt);
  assign bus.fence_done  = (count_r == '0) && (state_r != ST_WAIT);

  // Arbiter next state; an issued request stays on the port until granted
  always_comb begin
    state_s    = state_r;
    drive_st_s = 1'b0;
    drive_ld_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (drain_cond_s) begin
          drive_st_s = 1'b1;
          state_s    = bus.mem_gnt ? IDLE : ST_WAIT;
        end else if (ld_miss_s) begin
          drive_ld_s = 1'b1;
          state_s    = bus.mem_gnt ? IDLE : LD_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      ST_WAIT: begin
        drive_st_s = 1'b1;
        state_s    = bus.mem_gnt ? IDLE : ST_WAIT;
      end
      LD_WAIT: begin
        drive_ld_s = 1'b1;
        state_s    = bus.mem_gnt ? IDLE : LD_WAIT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Memory port mux: head entry for drains, live load inputs for loads
  always_comb begin
    bus.mem_req   = drive_st_s || drive_ld_s;
    bus.mem_we    = drive_st_s;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_be    = 4'h0;
    if (drive_st_s) begin
      bus.mem_addr  = head_s.addr;
      bus.mem_wdata = head_s.data;
      bus.mem_be    = head_s.be;
    end else if (drive_ld_s) begin
      bus.mem_addr = bus.ld_addr;
      bus.mem_be   = bus.ld_be;
    end else begin
      bus.mem_addr = 32'h0;
    end
  end

  // FIFO storage, pointers and arbiter state; enqueue and drain may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_r <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      state_r   <= IDLE;
    end else begin
      state_r <= state_s;
      if (enq_s) begin
        entries_r[tail_r] <= '{valid: 1'b1, addr: bus.st_addr, data: bus.st_data, be: bus.st_be};
        tail_r            <= tail_r + PTR_W'(1);
      end
      if (deq_s) begin
        entries_r[head_r].valid <= 1'b0;
        head_r                  <= head_r + PTR_W'(1);
      end
      count_r <= count_r + (PTR_W + 1)'(enq_s) - (PTR_W + 1)'(deq_s);
    end
  end

endmodule

// File: doc/store_buffer_ctrl.md
Name: store_buffer_ctrl

Overview:
Store buffer and memory-port scheduler that sits between the MEM stage and the single data-memory port. Retired stores are queued in a small FIFO and drained to memory in program order. Loads arbitrate against the drain for the same port. A load whose word address hits a pending store is satisfied by forwarding with no bubble, or is stalled until the conflicting store drains.

Parameters:
DEPTH, 4, number of store-buffer entries (power of two, >=2)
PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
st_valid  in  1  MEM stage presents a store
st_addr  in  32  store byte address (word-aligned part used for match)
st_data  in  32  store data, lane-aligned
st_be  in  4  store byte enables
st_ready  out  1  store accepted this cycle
ld_valid  in  1  MEM stage presents a load
ld_addr  in  32  load byte address
ld_be  in  4  load byte enables
ld_ready  out  1  load completes this cycle (forwarded or granted)
ld_sel_fwd  out  1  1 = load data comes from ld_fwd_data, 0 = from memory
ld_fwd_data  out  32  forwarded data, valid when ld_sel_fwd
fence  in  1  request full drain
fence_done  out  1  buffer empty and no drain outstanding
mem_req  out  1  memory port request
mem_we  out  1  1 = store drain, 0 = load
mem_addr  out  32  memory address
mem_wdata  out  32  drain data
mem_be  out  4  byte enables
mem_gnt  in  1  memory accepts request this cycle

Behaviour:
- Reset (async, rst_n=0): all entries invalid, head/tail/count=0, FSM=IDLE. st_ready=1 after reset release. ld_ready=0, ld_sel_fwd=0, ld_fwd_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, fence_done=1. Reset mid-drain discards all entries.
- Contract: st_valid and ld_valid are never both high in one cycle (bench assertion). A requester holds its inputs stable until accepted.
- Enqueue: st_ready = (count != DEPTH). On st_valid&&st_ready, write entry at tail, tail++ (wraps mod DEPTH), count++. No full-bypass: enqueue while full waits even if a drain grants the same cycle.
- Match (combinational): hit[i] = valid[i] && entry.addr[31:2]==ld_addr[31:2]. Youngest hit = first hit searching backward from tail-1, wrapping.
  - cover = (ld_be & ~youngest.be)==0.
  - Youngest hit covers: ld_ready=1, ld_sel_fwd=1, ld_fwd_data=youngest.data, zero latency, memory port untouched.
  - Hit without cover: ld_ready=0 (stall) and drain is forced until no hit remains.
  - No hit: load goes to the arbiter.
- Arbiter FSM, states IDLE, ST_WAIT, LD_WAIT:
  - IDLE, drain condition true (count>0 and (no ld_valid, or count==DEPTH, or fence, or partial-hit stall)): mem_req=1, mem_we=1, head entry on mem_*; -> ST_WAIT unless mem_gnt.
  - IDLE, otherwise a no-hit load: mem_req=1, mem_we=0, mem_addr=ld_addr, mem_be=ld_be; -> LD_WAIT unless mem_gnt.
  - Once issued, a request is never preempted. mem_* stay stable until mem_gnt.
  - On drain grant: head invalidated, head++, count--; -> IDLE.
  - On load grant: ld_ready=1, ld_sel_fwd=0; -> IDLE.
  - Same-cycle enqueue and drain grant: count unchanged, both pointers advance.
- fence_done = (count==0 && FSM!=ST_WAIT). fence is level-sensitive.

Decomposition:
- Package ls_pkg: sb_entry_t {valid, addr[31:0], data[31:0], be[3:0]}; arb_state_e {IDLE, ST_WAIT, LD_WAIT}; SB_DEPTH_DEFAULT=4; function word_addr().
- Sub-module sb_match: purely combinational youngest-hit finder. Inputs: entries, tail, ld_addr, ld_be. Outputs: any_hit, fwd_ok, fwd_data.

Test Plan:
- Store 0x100/0xDEADBEEF/be=F, then load 0x100 be=F next cycle, mem_gnt=0 -> ld_ready=1, ld_sel_fwd=1, ld_fwd_data=0xDEADBEEF, mem_req=0.
- Stores to 0x200 (0x11111111) then 0x200 (0x22222222), load 0x200 -> forwards 0x22222222 (youngest wins).
- Store 0x300 be=0x1 data 0x000000AA, load 0x300 be=F -> ld_ready=0. Drain issues mem_we=1 mem_addr=0x300; after mem_gnt, load goes to memory with mem_we=0; ld_ready on grant with ld_sel_fwd=0.
- Enqueue 4 stores with mem_gnt=0 -> st_ready=0 on 5th; mem_req held stable with 1st store. Then mem_gnt=1 for 1 cycle -> count=3, st_ready=1 next cycle. Drains observed in order and pointers wrap.
- Load to 0x400 (no hit) while a drain is in ST_WAIT -> load waits until drain mem_gnt, then mem_we=0 mem_addr=0x400.
- Two stores pending, fence=1 -> both drain back-to-back, fence_done=1 only after 2nd grant. Assert rst_n=0 mid-drain -> mem_req=0 immediately, count=0, fence_done=1.
